// File: rtl/vehicle_speed_ctrl_if.sv
// Pedal/gear/strobe inputs and speed/odometer outputs of the vehicle speed stage.
// tick_speed and tick_1sec are single-cycle strobes with no ready/back-pressure; levels are sampled on every clk edge.
interface vehicle_speed_ctrl_if;
    logic        tick_speed;
    logic        tick_1sec;
    logic        engine_on;
    logic        accel;
    logic        brake;
    logic [1:0]  gear;
    logic [7:0]  speed;
    logic        dir_rev;
    logic [1:0]  state;
    logic [13:0] odo_km;
    logic        overspeed;

    modport master (
        output tick_speed, tick_1sec, engine_on, accel, brake, gear,
        input  speed, dir_rev, state, odo_km, overspeed
    );

    modport slave (
        input  tick_speed, tick_1sec, engine_on, accel, brake, gear,
        output speed, dir_rev, state, odo_km, overspeed
    );
endinterface

// File: rtl/vehicle_speed_ctrl.sv
// Vehicle dynamics: integrates pedals/gear into speed on tick_speed and
// accumulates distance into a wrapping odometer on tick_1sec.
module vehicle_speed_ctrl #(
    parameter int unsigned ACC_STEP  = 3,
    parameter int unsigned BRK_STEP  = 5,
    parameter int unsigned DRAG_STEP = 1,
    parameter int unsigned MAX_FWD   = 200,
    parameter int unsigned MAX_REV   = 20,
    parameter int unsigned WARN_SPD  = 120,
    parameter int unsigned ODO_MAX   = 9999
) (
    input logic                 clk,
    input logic                 rst,
    vehicle_speed_ctrl_if.slave bus
);

    localparam logic [1:0] ST_OFF   = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_FWD   = 2'b10;
    localparam logic [1:0] ST_REV   = 2'b11;

    localparam logic [1:0] GEAR_R = 2'b01;
    localparam logic [1:0] GEAR_D = 2'b11;

    localparam logic [8:0]  ACC_W     = 9'(ACC_STEP);
    localparam logic [8:0]  BRK_W     = 9'(BRK_STEP);
    localparam logic [8:0]  DRAG_W    = 9'(DRAG_STEP);
    localparam logic [8:0]  MAX_FWD_W = 9'(MAX_FWD);
    localparam logic [8:0]  MAX_REV_W = 9'(MAX_REV);
    localparam logic [7:0]  WARN_W    = 8'(WARN_SPD);
    localparam logic [13:0] ODO_MAX_W = 14'(ODO_MAX);
    localparam logic [12:0] KM_DIST   = 13'd3600;

    logic [7:0]  speed_q, speed_d;
    logic [1:0]  state_q, state_d;
    logic        dir_rev_q, dir_rev_d;
    logic        overspeed_q, overspeed_d;
    logic [13:0] odo_q, odo_d;
    logic [11:0] dist_q, dist_d;

    logic [8:0]  spd_ext;
    logic [8:0]  spd_up;
    logic [8:0]  spd_nxt;
    logic [12:0] dist_sum;
    logic        fwd_match, rev_match;
    logic        launch_fwd, launch_rev;

    assign spd_ext  = {1'b0, speed_q};
    assign spd_up   = spd_ext + ACC_W;
    assign dist_sum = {1'b0, dist_q} + {5'd0, speed_q};

    // Reverse acceleration is only allowed up to the reverse ceiling; above it R just drags.
    assign fwd_match = bus.engine_on && bus.accel && (bus.gear == GEAR_D)
                       && ((state_q == ST_READY) || (state_q == ST_FWD));
    assign rev_match = bus.engine_on && bus.accel && (bus.gear == GEAR_R)
                       && ((state_q == ST_READY) || (state_q == ST_REV))
                       && (spd_ext <= MAX_REV_W);

    assign launch_fwd = bus.engine_on && bus.accel && !bus.brake && (bus.gear == GEAR_D);
    assign launch_rev = bus.engine_on && bus.accel && !bus.brake && (bus.gear == GEAR_R);

    always_comb begin
        spd_nxt = spd_ext;
        if (bus.tick_speed) begin
            if (bus.brake) begin
                spd_nxt = (spd_ext > BRK_W) ? (spd_ext - BRK_W) : 9'd0;
            end else if (fwd_match) begin
                spd_nxt = (spd_up > MAX_FWD_W) ? MAX_FWD_W : spd_up;
            end else if (rev_match) begin
                spd_nxt = (spd_up > MAX_REV_W) ? MAX_REV_W : spd_up;
            end else begin
                spd_nxt = (spd_ext > DRAG_W) ? (spd_ext - DRAG_W) : 9'd0;
            end
        end
        speed_d     = spd_nxt[7:0];
        overspeed_d = (speed_d > WARN_W);
    end

    // Distance uses the speed held before any same-cycle speed update.
    always_comb begin
        dist_d = dist_q;
        odo_d  = odo_q;
        if (bus.tick_1sec) begin
            if (dist_sum >= KM_DIST) begin
                dist_d = 12'(dist_sum - KM_DIST);
                odo_d  = (odo_q >= ODO_MAX_W) ? 14'd0 : odo_q + 14'd1;
            end else begin
                dist_d = dist_sum[11:0];
            end
        end
    end

    // A moving state only falls back once speed is 0 and the driver is not launching in that direction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (bus.engine_on && (speed_q == 8'd0)) state_d = ST_READY;
            end
            ST_READY: begin
                if (!bus.engine_on)   state_d = ST_OFF;
                else if (launch_fwd)  state_d = ST_FWD;
                else if (launch_rev)  state_d = ST_REV;
            end
            ST_FWD: begin
                if (speed_q == 8'd0) begin
                    if (!bus.engine_on)  state_d = ST_OFF;
                    else if (!launch_fwd) state_d = ST_READY;
                end
            end
            default: begin
                if (speed_q == 8'd0) begin
                    if (!bus.engine_on)  state_d = ST_OFF;
                    else if (!launch_rev) state_d = ST_READY;
                end
            end
        endcase
        dir_rev_d = (state_d == ST_REV);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed_q     <= 8'd0;
            state_q     <= ST_OFF;
            dir_rev_q   <= 1'b0;
            overspeed_q <= 1'b0;
            odo_q       <= 14'd0;
            dist_q      <= 12'd0;
        end else begin
            speed_q     <= speed_d;
            state_q     <= state_d;
            dir_rev_q   <= dir_rev_d;
            overspeed_q <= overspeed_d;
            odo_q       <= odo_d;
            dist_q      <= dist_d;
        end
    end

    assign bus.speed     = speed_q;
    assign bus.state     = state_q;
    assign bus.dir_rev   = dir_rev_q;
    assign bus.overspeed = overspeed_q;
    assign bus.odo_km    = odo_q;

endmodule

// File: tb/tb_vehicle_speed_ctrl.sv
// Bench for vehicle_speed_ctrl: directed driving scenarios followed by random
// pedal/gear segments, all scored against a behavioural vehicle model.
module tb_vehicle_speed_ctrl;
    // A small wrap value keeps the odometer rollover reachable in a short run.
    localparam int ODO_WRAP = 5;
    localparam int ST_OFF = 0, ST_READY = 1, ST_FWD = 2, ST_REV = 3;
    localparam int G_P = 0, G_R = 1, G_N = 2, G_D = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vehicle_speed_ctrl_if bus();

    vehicle_speed_ctrl #(.ODO_MAX(ODO_WRAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [25:0] exp_q[$];

    int m_speed, m_state, m_odo, m_dist;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Vehicle model: one call per clock, applying the driving rules to the current inputs.
    function automatic void model_step();
        int  pre, nxt, g;
        bit  eng, acc, brk, moving_fwd_ok, moving_rev_ok;
        pre = m_speed;
        g   = int'(bus.gear);
        eng = bus.engine_on;
        acc = bus.accel;
        brk = bus.brake;
        if (bus.tick_1sec) begin
            m_dist += pre;
            if (m_dist >= 3600) begin
                m_dist -= 3600;
                m_odo = (m_odo == ODO_WRAP) ? 0 : m_odo + 1;
            end
        end
        moving_fwd_ok = (m_state == ST_READY) || (m_state == ST_FWD);
        moving_rev_ok = (m_state == ST_READY) || (m_state == ST_REV);
        nxt = pre;
        if (bus.tick_speed) begin
            if (brk)                                               nxt = clamp(pre - 5, 0, 255);
            else if (acc && eng && g == G_D && moving_fwd_ok)      nxt = clamp(pre + 3, 0, 200);
            else if (acc && eng && g == G_R && moving_rev_ok && pre <= 20) nxt = clamp(pre + 3, 0, 20);
            else                                                   nxt = clamp(pre - 1, 0, 255);
        end
        case (m_state)
            ST_OFF:   if (eng && pre == 0) m_state = ST_READY;
            ST_READY: begin
                if (!eng) m_state = ST_OFF;
                else if (acc && !brk && g == G_D) m_state = ST_FWD;
                else if (acc && !brk && g == G_R) m_state = ST_REV;
            end
            default: begin
                if (pre == 0) begin
                    if (!eng) m_state = ST_OFF;
                    else if (!(acc && !brk && g == ((m_state == ST_FWD) ? G_D : G_R))) m_state = ST_READY;
                end
            end
        endcase
        m_speed = nxt;
    endfunction

    task automatic compare_outputs();
        logic [25:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("speed",     32'(bus.speed),     32'(e[25:18]));
        check("dir_rev",   32'(bus.dir_rev),   32'(e[17]));
        check("state",     32'(bus.state),     32'(e[16:15]));
        check("odo_km",    32'(bus.odo_km),    32'(e[14:1]));
        check("overspeed", 32'(bus.overspeed), 32'(e[0]));
    endtask

    task automatic step();
        model_step();
        exp_q.push_back({8'(m_speed), (m_state == ST_REV), 2'(m_state), 14'(m_odo), (m_speed > 120)});
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic drive(input bit eng, input bit acc, input bit brk, input int g);
        bus.engine_on = eng;
        bus.accel     = acc;
        bus.brake     = brk;
        bus.gear      = 2'(g);
    endtask

    task automatic run(input int n, input bit ts, input bit t1);
        bus.tick_speed = ts;
        bus.tick_1sec  = t1;
        for (int i = 0; i < n; i++) step();
        bus.tick_speed = 1'b0;
        bus.tick_1sec  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_speed", 32'(bus.speed), 32'd0);
        check("rst_state", 32'(bus.state), 32'(ST_OFF));
        check("rst_dir",   32'(bus.dir_rev), 32'd0);
        check("rst_odo",   32'(bus.odo_km), 32'd0);
        check("rst_ovs",   32'(bus.overspeed), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_speed = 0; m_state = ST_OFF; m_odo = 0; m_dist = 0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seg_len, g;
        bit eng, acc, brk;
        bus.tick_speed = 1'b0;
        bus.tick_1sec  = 1'b0;
        drive(0, 0, 0, G_P);
        repeat (3) @(posedge clk);
        do_reset();

        // Launch in D and accelerate for 10 speed ticks.
        drive(1, 1, 0, G_D);
        run(2, 0, 0);
        run(10, 1, 0);
        check("t1_speed", 32'(bus.speed), 32'd30);
        check("t1_state", 32'(bus.state), 32'(ST_FWD));
        check("t1_dir",   32'(bus.dir_rev), 32'd0);

        // Brake wins over accel and saturates at zero.
        drive(1, 1, 1, G_D);
        run(6, 1, 0);
        check("t2_speed", 32'(bus.speed), 32'd0);
        run(1, 0, 0);
        check("t2_state", 32'(bus.state), 32'(ST_READY));

        // Reverse clamps at 20; switching to D while reversing only drags.
        drive(1, 1, 0, G_R);
        run(10, 1, 0);
        check("t3_speed", 32'(bus.speed), 32'd20);
        check("t3_dir",   32'(bus.dir_rev), 32'd1);
        drive(1, 1, 0, G_D);
        run(1, 1, 0);
        check("t3_drag", 32'(bus.speed), 32'd19);
        run(19, 1, 0);
        check("t3_zero", 32'(bus.speed), 32'd0);
        run(1, 0, 0);
        check("t3_ready", 32'(bus.state), 32'(ST_READY));

        // Cruise at 200: 18 seconds make one km, then the odometer wraps.
        run(70, 1, 0);
        check("t4_speed", 32'(bus.speed), 32'd200);
        run(18, 0, 1);
        check("t4_odo1", 32'(bus.odo_km), 32'd1);
        run(18 * ODO_WRAP, 0, 1);
        check("t4_wrap", 32'(bus.odo_km), 32'd0);

        // Both strobes together at 100, then creep up past the warning threshold.
        drive(1, 0, 1, G_D);
        run(20, 1, 0);
        check("t5_speed100", 32'(bus.speed), 32'd100);
        drive(1, 1, 0, G_D);
        run(1, 1, 1);
        check("t5_speed103", 32'(bus.speed), 32'd103);
        run(5, 1, 0);
        check("t5_ovs_lo", 32'(bus.overspeed), 32'd0);
        run(1, 1, 0);
        check("t5_speed121", 32'(bus.speed), 32'd121);
        check("t5_ovs_hi", 32'(bus.overspeed), 32'd1);

        // Reset mid-drive, then accel with engine off goes nowhere.
        run(10, 1, 1);
        do_reset();
        drive(0, 1, 0, G_D);
        run(5, 1, 0);
        check("t6_speed", 32'(bus.speed), 32'd0);
        check("t6_state", 32'(bus.state), 32'(ST_OFF));

        // Random driving segments.
        for (int s = 0; s < 90; s++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            seg_len = $urandom_range(5, 60);
            eng = ($urandom_range(0, 9) != 0);
            acc = ($urandom_range(0, 9) < 7);
            brk = ($urandom_range(0, 19) < 3);
            g   = (($urandom_range(0, 2) != 0) ? G_D : $urandom_range(0, 3));
            drive(eng, acc, brk, g);
            for (int c = 0; c < seg_len; c++) begin
                if ($urandom_range(0, 29) == 0) bus.gear = 2'($urandom_range(0, 3));
                bus.tick_speed = ($urandom_range(0, 1) == 1);
                bus.tick_1sec  = ($urandom_range(0, 3) == 0);
                step();
            end
            bus.tick_speed = 1'b0;
            bus.tick_1sec  = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
